// File: rtl/kernel_dispatcher.sv
// Kernel launch unit: addressed DCR file plus block dispatch onto a pool of cores.
// Blocks go to the lowest-indexed free core; finished cores are refilled on the next edge.
module kernel_dispatcher #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned DCR_ADDR_WIDTH    = 2,
    localparam int unsigned TCW              = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dcr_write_enable,
    input  logic [DCR_ADDR_WIDTH-1:0] dcr_write_addr,
    input  logic [DATA_WIDTH-1:0]     dcr_write_data,
    input  logic                      start,
    input  logic                      abort,
    output logic                      done,
    output logic                      busy,
    output logic [DATA_WIDTH-1:0]     blocks_done,
    input  logic [NUM_CORES-1:0]      core_done,
    output logic [NUM_CORES-1:0]      core_start,
    output logic [NUM_CORES-1:0]      core_rst_n,
    output logic [DATA_WIDTH-1:0]     core_block_id     [NUM_CORES],
    output logic [TCW-1:0]            core_thread_count [NUM_CORES]
);

    typedef enum logic [1:0] {StIdle, StDispatch, StDone} state_e;
    typedef enum logic [1:0] {CoreFree, CoreReset, CoreRun} core_state_e;

    state_e                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  kill_q, kill_d;
    logic [DATA_WIDTH-1:0] blocks_done_q, blocks_done_d;
    logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] next_id_q, next_id_d;
    logic [DATA_WIDTH-1:0] thread_count_q, thread_count_d;
    logic [TCW-1:0]        block_size_q, block_size_d;
    logic [DATA_WIDTH-1:0] block_id_base_q, block_id_base_d;

    core_state_e           core_state_q [NUM_CORES];
    core_state_e           core_state_d [NUM_CORES];
    logic [DATA_WIDTH-1:0] core_block_id_q [NUM_CORES];
    logic [DATA_WIDTH-1:0] core_block_id_d [NUM_CORES];
    logic [TCW-1:0]        core_thread_count_q [NUM_CORES];
    logic [TCW-1:0]        core_thread_count_d [NUM_CORES];

    logic                  all_free;
    logic                  assigned;
    logic [DATA_WIDTH-1:0] finished_cnt;
    logic [TCW-1:0]        blk_cnt;

    always_comb begin
        state_d             = state_q;
        busy_d              = busy_q;
        done_d              = done_q;
        kill_d              = 1'b0;
        remaining_d         = remaining_q;
        next_id_d           = next_id_q;
        thread_count_d      = thread_count_q;
        block_size_d        = block_size_q;
        block_id_base_d     = block_id_base_q;
        core_state_d        = core_state_q;
        core_block_id_d     = core_block_id_q;
        core_thread_count_d = core_thread_count_q;
        all_free            = 1'b1;
        assigned            = 1'b0;
        finished_cnt        = '0;

        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (core_state_q[i] != CoreFree) all_free = 1'b0;
        end
        blk_cnt = (32'(remaining_q) < 32'(block_size_q)) ? TCW'(remaining_q) : block_size_q;

        if (dcr_write_enable && !busy_q) begin
            case (32'(dcr_write_addr))
                32'd0: thread_count_d = dcr_write_data;
                32'd1: block_size_d = (dcr_write_data == '0 ||
                                       32'(dcr_write_data) > THREADS_PER_BLOCK) ?
                                      TCW'(THREADS_PER_BLOCK) : TCW'(dcr_write_data);
                32'd2: block_id_base_d = dcr_write_data;
                default: ;
            endcase
        end

        // core_done is only meaningful while a core is running a block
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            case (core_state_q[i])
                CoreReset: core_state_d[i] = CoreRun;
                CoreRun: begin
                    if (core_done[i]) begin
                        core_state_d[i] = CoreFree;
                        finished_cnt    = finished_cnt + DATA_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
        blocks_done_d = blocks_done_q + finished_cnt;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // An empty kernel passes through one idle dispatch cycle with busy low
                    state_d       = StDispatch;
                    busy_d        = (thread_count_q != '0);
                    done_d        = 1'b0;
                    blocks_done_d = '0;
                    remaining_d   = thread_count_q;
                    next_id_d     = block_id_base_q;
                end
            end
            StDispatch: begin
                if (busy_q && abort) begin
                    state_d       = StIdle;
                    busy_d        = 1'b0;
                    done_d        = 1'b0;
                    kill_d        = 1'b1;
                    blocks_done_d = blocks_done_q;
                    for (int i = 0; i < int'(NUM_CORES); i++) core_state_d[i] = CoreFree;
                end else if (remaining_q == '0) begin
                    if (all_free) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    for (int i = 0; i < int'(NUM_CORES); i++) begin
                        if (!assigned && core_state_q[i] == CoreFree) begin
                            assigned               = 1'b1;
                            core_state_d[i]        = CoreReset;
                            core_block_id_d[i]     = next_id_q;
                            core_thread_count_d[i] = blk_cnt;
                        end
                    end
                    if (assigned) begin
                        next_id_d   = next_id_q + DATA_WIDTH'(1);
                        remaining_d = remaining_q - DATA_WIDTH'(blk_cnt);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            kill_q          <= 1'b1;
            blocks_done_q   <= '0;
            remaining_q     <= '0;
            next_id_q       <= '0;
            thread_count_q  <= '0;
            block_size_q    <= TCW'(THREADS_PER_BLOCK);
            block_id_base_q <= '0;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                core_state_q[i]        <= CoreFree;
                core_block_id_q[i]     <= '0;
                core_thread_count_q[i] <= '0;
            end
        end else begin
            state_q             <= state_d;
            busy_q              <= busy_d;
            done_q              <= done_d;
            kill_q              <= kill_d;
            blocks_done_q       <= blocks_done_d;
            remaining_q         <= remaining_d;
            next_id_q           <= next_id_d;
            thread_count_q      <= thread_count_d;
            block_size_q        <= block_size_d;
            block_id_base_q     <= block_id_base_d;
            core_state_q        <= core_state_d;
            core_block_id_q     <= core_block_id_d;
            core_thread_count_q <= core_thread_count_d;
        end
    end

    always_comb begin
        busy        = busy_q;
        done        = done_q;
        blocks_done = blocks_done_q;
        core_start  = '0;
        core_rst_n  = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            core_start[i]        = (core_state_q[i] == CoreRun);
            core_rst_n[i]        = !kill_q && (core_state_q[i] != CoreReset);
            core_block_id[i]     = core_block_id_q[i];
            core_thread_count[i] = core_thread_count_q[i];
        end
    end

endmodule

// File: tb/tb_kernel_dispatcher.sv
// Bench for kernel_dispatcher: directed launch/abort/empty cases, then random traffic
// checked every cycle against a timestamp-based reference model.
module tb_kernel_dispatcher;

    localparam int NC  = 2;
    localparam int DW  = 8;
    localparam int TPB = 4;
    localparam int AW  = 2;
    localparam int TCW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dcr_write_enable;
    logic [AW-1:0] dcr_write_addr;
    logic [DW-1:0] dcr_write_data;
    logic          start;
    logic          abort;
    logic          done;
    logic          busy;
    logic [DW-1:0] blocks_done;
    logic [NC-1:0] core_done;
    logic [NC-1:0] core_start;
    logic [NC-1:0] core_rst_n;
    logic [DW-1:0] core_block_id     [NC];
    logic [TCW-1:0] core_thread_count [NC];

    always #5 clk = ~clk;

    kernel_dispatcher #(
        .DATA_WIDTH       (DW),
        .NUM_CORES        (NC),
        .THREADS_PER_BLOCK(TPB),
        .DCR_ADDR_WIDTH   (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dcr_write_enable (dcr_write_enable),
        .dcr_write_addr   (dcr_write_addr),
        .dcr_write_data   (dcr_write_data),
        .start            (start),
        .abort            (abort),
        .done             (done),
        .busy             (busy),
        .blocks_done      (blocks_done),
        .core_done        (core_done),
        .core_start       (core_start),
        .core_rst_n       (core_rst_n),
        .core_block_id    (core_block_id),
        .core_thread_count(core_thread_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each core remembers the edge it was handed a block; its reset
    // pulse is the cycle after that edge and it runs from the following edge on.
    int unsigned n = 0;
    int unsigned m_tc, m_bs, m_base, m_rem, m_next, m_blocks;
    bit          m_busy, m_done, m_empty, m_kill;
    bit          m_valid = 1'b0;
    bit          m_act [NC];
    int unsigned m_asg [NC];
    int unsigned m_id  [NC];
    int unsigned m_cnt [NC];

    always @(posedge clk) begin : model
        bit pre_act [NC];
        bit pre_busy;
        bit all_free;
        int sel;
        n = n + 1;
        if (!rst_n) begin
            m_tc = 0; m_bs = TPB; m_base = 0; m_rem = 0; m_next = 0; m_blocks = 0;
            m_busy = 0; m_done = 0; m_empty = 0; m_kill = 1; m_valid = 1;
            for (int i = 0; i < NC; i++) begin
                m_act[i] = 0; m_asg[i] = 0; m_id[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            pre_act  = m_act;
            pre_busy = m_busy;
            m_kill   = 0;
            all_free = 1;
            for (int i = 0; i < NC; i++) if (pre_act[i]) all_free = 0;
            if (m_busy && abort) begin
                for (int i = 0; i < NC; i++) m_act[i] = 0;
                m_busy = 0; m_done = 0; m_kill = 1;
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (m_act[i] && core_done[i] && n >= m_asg[i] + 2) begin
                        m_act[i] = 0;
                        m_blocks = (m_blocks + 1) % 256;
                    end
                end
                if (m_empty) begin
                    m_empty = 0; m_done = 1;
                end else if (m_busy) begin
                    if (m_rem == 0 && all_free) begin
                        m_busy = 0; m_done = 1;
                    end else if (m_rem > 0) begin
                        sel = -1;
                        for (int i = 0; i < NC; i++) if (sel < 0 && !pre_act[i]) sel = i;
                        if (sel >= 0) begin
                            m_act[sel] = 1;
                            m_asg[sel] = n;
                            m_id[sel]  = m_next;
                            m_cnt[sel] = (m_rem < m_bs) ? m_rem : m_bs;
                            m_next     = (m_next + 1) % 256;
                            m_rem      = m_rem - m_cnt[sel];
                        end
                    end
                end else if (start) begin
                    m_done = 0; m_blocks = 0; m_rem = m_tc; m_next = m_base;
                    if (m_tc == 0) m_empty = 1;
                    else m_busy = 1;
                end
            end
            if (dcr_write_enable && !pre_busy) begin
                case (int'(dcr_write_addr))
                    0: m_tc = dcr_write_data;
                    1: m_bs = (dcr_write_data == 0 || dcr_write_data > TPB) ? TPB : dcr_write_data;
                    2: m_base = dcr_write_data;
                    default: ;
                endcase
            end
        end
    end

    task automatic compare_all();
        logic [NC-1:0] es, er;
        for (int i = 0; i < NC; i++) begin
            es[i] = m_act[i] && (n > m_asg[i]);
            er[i] = !m_kill && !(m_act[i] && n == m_asg[i]);
        end
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("blocks_done", 32'(blocks_done), m_blocks);
        check_eq("core_start", 32'(core_start), 32'(es));
        check_eq("core_rst_n", 32'(core_rst_n), 32'(er));
        for (int i = 0; i < NC; i++) begin
            check_eq($sformatf("core%0d_block_id", i), 32'(core_block_id[i]), m_id[i]);
            check_eq($sformatf("core%0d_thread_count", i), 32'(core_thread_count[i]), m_cnt[i]);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (m_valid) compare_all();
    endtask

    task automatic dcr_wr(input int addr, input int data);
        dcr_write_enable = 1'b1;
        dcr_write_addr   = AW'(addr);
        dcr_write_data   = DW'(data);
        cyc();
        dcr_write_enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dcr_write_enable = 1'b0; dcr_write_addr = '0; dcr_write_data = '0;
        start = 1'b0; abort = 1'b0; core_done = '0;
        cyc();
        check_eq("rst_core_rst_n", 32'(core_rst_n), 32'h0);
        rst_n = 1'b1;
        cyc();
        check_eq("rst_core_rst_n_rel", 32'(core_rst_n), 32'h3);

        // Partial last block: 10 threads in blocks of 4, core 1 finishes first
        dcr_wr(0, 10); dcr_wr(1, 4); dcr_wr(2, 0);
        start = 1'b1; cyc(); start = 1'b0;
        check_eq("p_busy", 32'(busy), 32'h1);
        cyc(); cyc();
        check_eq("p_core1_id", 32'(core_block_id[1]), 32'd1);
        check_eq("p_core1_cnt", 32'(core_thread_count[1]), 32'd4);
        cyc(); cyc();
        core_done = 2'b10; cyc();
        core_done = 2'b01; cyc();
        core_done = 2'b00;
        check_eq("p_refill_id", 32'(core_block_id[1]), 32'd2);
        check_eq("p_refill_cnt", 32'(core_thread_count[1]), 32'd2);
        check_eq("p_refill_rst", 32'(core_rst_n), 32'h1);
        cyc(); cyc();
        core_done = 2'b10; cyc();
        core_done = 2'b00; cyc();
        check_eq("p_done", 32'(done), 32'h1);
        check_eq("p_blocks", 32'(blocks_done), 32'd3);
        check_eq("p_busy_end", 32'(busy), 32'h0);

        // Empty kernel
        dcr_wr(0, 0);
        start = 1'b1; cyc(); start = 1'b0;
        check_eq("e_done_clr", 32'(done), 32'h0);
        check_eq("e_busy", 32'(busy), 32'h0);
        cyc();
        check_eq("e_done", 32'(done), 32'h1);
        check_eq("e_start", 32'(core_start), 32'h0);

        // Abort with both cores running; DCR write during busy must be dropped
        dcr_wr(0, 8);
        start = 1'b1; cyc(); start = 1'b0;
        dcr_write_enable = 1'b1; dcr_write_addr = 2'd0; dcr_write_data = 8'd3;
        cyc();
        dcr_write_enable = 1'b0;
        cyc(); cyc();
        check_eq("a_running", 32'(core_start), 32'h3);
        abort = 1'b1; cyc(); abort = 1'b0;
        check_eq("a_rst_n", 32'(core_rst_n), 32'h0);
        check_eq("a_start", 32'(core_start), 32'h0);
        check_eq("a_busy", 32'(busy), 32'h0);
        check_eq("a_done", 32'(done), 32'h0);
        cyc();
        check_eq("a_rst_n_rel", 32'(core_rst_n), 32'h3);
        start = 1'b1; cyc(); start = 1'b0;
        core_done = 2'b11;
        repeat (8) cyc();
        core_done = 2'b00;
        check_eq("a_relaunch_done", 32'(done), 32'h1);
        check_eq("a_relaunch_blocks", 32'(blocks_done), 32'd2);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            int a;
            rst_n            = ($urandom % 400) != 0;
            start            = ($urandom % 4) == 0;
            abort            = ($urandom % 48) == 0;
            dcr_write_enable = ($urandom % 6) == 0;
            a                = int'($urandom % 4);
            dcr_write_addr   = AW'(a);
            dcr_write_data   = (a == 0) ? DW'($urandom % 24) :
                               (a == 1) ? DW'($urandom % 8) : DW'($urandom);
            for (int i = 0; i < NC; i++) core_done[i] = ($urandom % 3) == 0;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
